// File: rtl/screen_mux_sync_if.sv
// ============================================================================
// Module   : screen_mux_sync_if
// Brief    : Bundle of the per-screen VGA streams, mouse/request controls and
//            the selected output stream for screen_mux_sync.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface screen_mux_sync_if #(
   parameter int NUM_SCREENS = 4
);
   localparam int SEL_W = (NUM_SCREENS > 1) ? $clog2(NUM_SCREENS) : 1;

   logic                      mouse_left;
   logic [11:0]               xpos;
   logic [11:0]               ypos;
   logic                      req_valid;
   logic [SEL_W-1:0]          req_idx;
   logic [12*NUM_SCREENS-1:0] hcount_in;
   logic [12*NUM_SCREENS-1:0] vcount_in;
   logic [12*NUM_SCREENS-1:0] rgb_in;
   logic [NUM_SCREENS-1:0]    hsync_in;
   logic [NUM_SCREENS-1:0]    hblnk_in;
   logic [NUM_SCREENS-1:0]    vsync_in;
   logic [NUM_SCREENS-1:0]    vblnk_in;
   logic [11:0]               hcount_out;
   logic [11:0]               vcount_out;
   logic [11:0]               rgb_out;
   logic                      hsync_out;
   logic                      hblnk_out;
   logic                      vsync_out;
   logic                      vblnk_out;
   logic [SEL_W-1:0]          screen_sel;
   logic                      switching;

   modport master (
      output mouse_left, xpos, ypos, req_valid, req_idx,
      output hcount_in, vcount_in, rgb_in, hsync_in, hblnk_in, vsync_in, vblnk_in,
      input  hcount_out, vcount_out, rgb_out, hsync_out, hblnk_out, vsync_out, vblnk_out,
      input  screen_sel, switching
   );

   modport slave (
      input  mouse_left, xpos, ypos, req_valid, req_idx,
      input  hcount_in, vcount_in, rgb_in, hsync_in, hblnk_in, vsync_in, vblnk_in,
      output hcount_out, vcount_out, rgb_out, hsync_out, hblnk_out, vsync_out, vblnk_out,
      output screen_sel, switching
   );
endinterface

`default_nettype wire

// File: rtl/screen_mux_sync.sv
// ============================================================================
// Module   : screen_mux_sync
// Brief    : N-way VGA stream selector that switches only on a frame edge,
//            optionally followed by black frames.
// Revision : 1.0
// ============================================================================
`default_nettype none

module screen_mux_sync #(
   parameter int NUM_SCREENS  = 4,
   parameter int INIT_SCREEN  = 0,
   parameter int BTN_X        = 485,
   parameter int BTN_Y        = 358,
   parameter int BTN_W        = 54,
   parameter int BTN_H        = 53,
   parameter int WRAP         = 1,
   parameter int BLANK_FRAMES = 1,
   parameter int PIPE_STAGES  = 2
) (
   input  logic               pclk,
   input  logic               rst,
   screen_mux_sync_if.slave   bus
);
   localparam int SEL_W = (NUM_SCREENS > 1) ? $clog2(NUM_SCREENS) : 1;
   localparam int W     = 40;
   localparam logic [SEL_W-1:0] c_LAST_SEL    = SEL_W'(NUM_SCREENS - 1);
   localparam logic [SEL_W-1:0] c_INIT_SEL    = SEL_W'(INIT_SCREEN);
   localparam logic [3:0]       c_BLANK_LAST  = 4'((BLANK_FRAMES > 0) ? BLANK_FRAMES - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_PENDING = 2'd1,
      S_BLANK   = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [SEL_W-1:0] sel_q, sel_d;
   logic [SEL_W-1:0] tgt_q, tgt_d;
   logic [3:0]       blank_cnt_q, blank_cnt_d;
   logic             btn_prev_q, btn_prev_d;
   logic             vblnk_prev_q, vblnk_prev_d;
   logic [W-1:0]     pipe_q [PIPE_STAGES];
   logic [W-1:0]     stage1_d;

   logic [11:0] w_hc  [NUM_SCREENS];
   logic [11:0] w_vc  [NUM_SCREENS];
   logic [11:0] w_rgb [NUM_SCREENS];

   for (genvar i = 0; i < NUM_SCREENS; i++) begin : g_unpack
      assign w_hc[i]  = bus.hcount_in[12*i +: 12];
      assign w_vc[i]  = bus.vcount_in[12*i +: 12];
      assign w_rgb[i] = bus.rgb_in[12*i +: 12];
   end

   logic w_in_btn, w_click, w_vblnk_cur, w_frame_edge, w_req_ok;

   assign w_in_btn = ({1'b0, bus.xpos} >= 13'(BTN_X)) && ({1'b0, bus.xpos} < 13'(BTN_X + BTN_W)) &&
                     ({1'b0, bus.ypos} >= 13'(BTN_Y)) && ({1'b0, bus.ypos} < 13'(BTN_Y + BTN_H));
   assign w_click      = bus.mouse_left & ~btn_prev_q & w_in_btn;
   assign w_vblnk_cur  = bus.vblnk_in[sel_q];
   assign w_frame_edge = w_vblnk_cur & ~vblnk_prev_q;
   assign w_req_ok     = bus.req_valid && (32'(bus.req_idx) < NUM_SCREENS) && (bus.req_idx != sel_q);

   assign stage1_d = {w_hc[sel_q], w_vc[sel_q], (state_q == S_BLANK) ? 12'h000 : w_rgb[sel_q],
                      bus.hsync_in[sel_q], bus.hblnk_in[sel_q], bus.vsync_in[sel_q], w_vblnk_cur};

   always_comb begin
      state_d      = state_q;
      sel_d        = sel_q;
      tgt_d        = tgt_q;
      blank_cnt_d  = blank_cnt_q;
      btn_prev_d   = bus.mouse_left;
      vblnk_prev_d = w_vblnk_cur;
      case (state_q)
         S_IDLE: begin
            if (w_req_ok) begin
               tgt_d   = bus.req_idx;
               state_d = S_PENDING;
            end else if (w_click) begin
               if (sel_q != c_LAST_SEL) begin
                  tgt_d   = sel_q + SEL_W'(1);
                  state_d = S_PENDING;
               end else if (WRAP != 0) begin
                  tgt_d   = '0;
                  state_d = S_PENDING;
               end
            end
         end
         S_PENDING: begin
            if (w_frame_edge) begin
               sel_d        = tgt_q;
               // The new source may already be in vblank; don't count that as an edge.
               vblnk_prev_d = 1'b1;
               blank_cnt_d  = '0;
               state_d      = (BLANK_FRAMES > 0) ? S_BLANK : S_IDLE;
            end
         end
         S_BLANK: begin
            if (w_frame_edge) begin
               blank_cnt_d = blank_cnt_q + 4'd1;
               if (blank_cnt_q == c_BLANK_LAST) begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         state_q      <= S_IDLE;
         sel_q        <= c_INIT_SEL;
         tgt_q        <= c_INIT_SEL;
         blank_cnt_q  <= '0;
         btn_prev_q   <= 1'b0;
         vblnk_prev_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         sel_q        <= sel_d;
         tgt_q        <= tgt_d;
         blank_cnt_q  <= blank_cnt_d;
         btn_prev_q   <= btn_prev_d;
         vblnk_prev_q <= vblnk_prev_d;
      end
   end

   always_ff @(posedge pclk or posedge rst) begin
      if (rst) begin
         for (int s = 0; s < PIPE_STAGES; s++) pipe_q[s] <= '0;
      end else begin
         pipe_q[0] <= stage1_d;
         for (int s = 1; s < PIPE_STAGES; s++) pipe_q[s] <= pipe_q[s-1];
      end
   end

   assign {bus.hcount_out, bus.vcount_out, bus.rgb_out,
           bus.hsync_out, bus.hblnk_out, bus.vsync_out, bus.vblnk_out} = pipe_q[PIPE_STAGES-1];
   assign bus.screen_sel = sel_q;
   assign bus.switching  = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_screen_mux_sync.sv
// ============================================================================
// Module   : tb_screen_mux_sync
// Brief    : Two instances (wrap+1 blank frame, no-wrap+no blank) driven with
//            phase-shifted synthetic streams and checked against a cycle model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_screen_mux_sync;
   localparam int N    = 4;
   localparam int PIPE = 2;

   logic pclk = 1'b0;
   logic rst  = 1'b0;
   always #5 pclk = ~pclk;

   screen_mux_sync_if #(.NUM_SCREENS(N)) ifa ();
   screen_mux_sync_if #(.NUM_SCREENS(N)) ifb ();

   screen_mux_sync #(.NUM_SCREENS(N), .INIT_SCREEN(0), .BTN_X(485), .BTN_Y(358), .BTN_W(54),
                     .BTN_H(53), .WRAP(1), .BLANK_FRAMES(1), .PIPE_STAGES(PIPE))
      dut_a (.pclk(pclk), .rst(rst), .bus(ifa));
   screen_mux_sync #(.NUM_SCREENS(N), .INIT_SCREEN(0), .BTN_X(485), .BTN_Y(358), .BTN_W(54),
                     .BTN_H(53), .WRAP(0), .BLANK_FRAMES(0), .PIPE_STAGES(PIPE))
      dut_b (.pclk(pclk), .rst(rst), .bus(ifb));

   int n_tests = 0;
   int n_fail  = 0;
   int cnt     = 0;
   logic        ml = 1'b0;
   logic [11:0] x  = '0, y = '0;
   logic        rv = 1'b0;
   logic [1:0]  ri = '0;

   // reference model state, index 0 = dut_a, 1 = dut_b
   int   m_sel[2], m_tgt[2], m_st[2], m_bc[2];
   bit   m_btn[2], m_vp[2];
   int   m_wrap[2]  = '{1, 0};
   int   m_blank[2] = '{1, 0};
   logic [39:0] sbq [2][$];

   typedef struct {
      bit click; int x; int y; int hold; bit rv; int ri; int exp_a; int exp_b;
   } vec_t;
   vec_t tbl[13];

   // Screen i runs a 16x8 frame shifted by 13*i pixels; vblank is rows 6..7.
   function automatic logic [39:0] sw(int i, int c);
      int pos, hc, vc;
      pos = (c + 13*i) % 128;
      hc  = pos % 16;
      vc  = pos / 16;
      return {12'(hc + 16*i), 12'(vc + 8*i), 12'((i + 1)*257 + pos),
              (hc >= 12 && hc < 14), (hc >= 11), (vc == 6), (vc >= 6)};
   endfunction

   function automatic logic [39:0] out_word(int k);
      if (k == 0)
         return {ifa.hcount_out, ifa.vcount_out, ifa.rgb_out,
                 ifa.hsync_out, ifa.hblnk_out, ifa.vsync_out, ifa.vblnk_out};
      return {ifb.hcount_out, ifb.vcount_out, ifb.rgb_out,
              ifb.hsync_out, ifb.hblnk_out, ifb.vsync_out, ifb.vblnk_out};
   endfunction

   function automatic logic [39:0] out_sel(int k);
      return (k == 0) ? 40'(ifa.screen_sel) : 40'(ifb.screen_sel);
   endfunction

   function automatic logic [39:0] out_sw(int k);
      return (k == 0) ? 40'(ifa.switching) : 40'(ifb.switching);
   endfunction

   task automatic chk(string nm, int k, logic [39:0] got, logic [39:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d got=%h expected=%h at %0t", nm, k, got, exp, $time);
      end
   endtask

   task automatic drive();
      logic [39:0] w;
      for (int i = 0; i < N; i++) begin
         w = sw(i, cnt);
         ifa.hcount_in[12*i +: 12] = w[39:28]; ifb.hcount_in[12*i +: 12] = w[39:28];
         ifa.vcount_in[12*i +: 12] = w[27:16]; ifb.vcount_in[12*i +: 12] = w[27:16];
         ifa.rgb_in[12*i +: 12]    = w[15:4];  ifb.rgb_in[12*i +: 12]    = w[15:4];
         ifa.hsync_in[i] = w[3]; ifb.hsync_in[i] = w[3];
         ifa.hblnk_in[i] = w[2]; ifb.hblnk_in[i] = w[2];
         ifa.vsync_in[i] = w[1]; ifb.vsync_in[i] = w[1];
         ifa.vblnk_in[i] = w[0]; ifb.vblnk_in[i] = w[0];
      end
      ifa.mouse_left = ml; ifb.mouse_left = ml;
      ifa.xpos = x;        ifb.xpos = x;
      ifa.ypos = y;        ifb.ypos = y;
      ifa.req_valid = rv;  ifb.req_valid = rv;
      ifa.req_idx = ri;    ifb.req_idx = ri;
   endtask

   task automatic m_rst(int k);
      m_sel[k] = 0; m_tgt[k] = 0; m_st[k] = 0; m_bc[k] = 0;
      m_btn[k] = 1'b0; m_vp[k] = 1'b1;
      sbq[k].delete();
      for (int s = 0; s < PIPE - 1; s++) sbq[k].push_back('0);
   endtask

   task automatic model_step(int k);
      logic [39:0] w;
      bit inbox, click, vb, fe;
      if (rst) begin
         m_rst(k);
         return;
      end
      w = sw(m_sel[k], cnt);
      if (m_st[k] == 2) w[15:4] = '0;
      sbq[k].push_back(w);
      inbox = (x >= 485) && (x < 539) && (y >= 358) && (y < 411);
      click = ml && !m_btn[k] && inbox;
      vb    = w[0];
      fe    = vb && !m_vp[k];
      m_btn[k] = ml;
      m_vp[k]  = vb;
      case (m_st[k])
         0: begin
            if (rv && int'(ri) != m_sel[k]) begin
               m_tgt[k] = int'(ri); m_st[k] = 1;
            end else if (click) begin
               if (m_sel[k] != N - 1) begin
                  m_tgt[k] = m_sel[k] + 1; m_st[k] = 1;
               end else if (m_wrap[k] != 0) begin
                  m_tgt[k] = 0; m_st[k] = 1;
               end
            end
         end
         1: if (fe) begin
            m_sel[k] = m_tgt[k]; m_vp[k] = 1'b1; m_bc[k] = 0;
            m_st[k]  = (m_blank[k] > 0) ? 2 : 0;
         end
         default: if (fe) begin
            if (m_bc[k] == m_blank[k] - 1) m_st[k] = 0;
            m_bc[k]++;
         end
      endcase
   endtask

   task automatic check(int k);
      logic [39:0] exp;
      exp = (sbq[k].size() > PIPE - 1) ? sbq[k].pop_front() : 40'h0;
      chk("video", k, out_word(k), exp);
      chk("screen_sel", k, out_sel(k), 40'(m_sel[k]));
      chk("switching", k, out_sw(k), 40'(m_st[k] != 0));
   endtask

   task automatic tick();
      drive();
      @(posedge pclk);
      model_step(0);
      model_step(1);
      #1;
      check(0);
      check(1);
      cnt = (cnt + 1) % 128;
   endtask

   initial begin
      #5_000_000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      tbl[0]  = '{1, 500, 380,   1, 0, 0, 1, 1};
      tbl[1]  = '{1, 484, 380,   1, 0, 0, 1, 1};
      tbl[2]  = '{1, 500, 411,   1, 0, 0, 1, 1};
      tbl[3]  = '{1, 500, 380, 400, 0, 0, 2, 2};
      tbl[4]  = '{0,   0,   0,   1, 1, 2, 2, 2};
      tbl[5]  = '{1, 500, 380,   1, 1, 3, 3, 3};
      tbl[6]  = '{1, 500, 380,   1, 0, 0, 0, 3};
      tbl[7]  = '{0,   0,   0,   1, 1, 1, 1, 1};
      tbl[8]  = '{1, 500, 380,   1, 1, 1, 2, 2};
      tbl[9]  = '{0,   0,   0,   1, 1, 0, 0, 0};
      tbl[10] = '{1, 485, 358,   1, 0, 0, 1, 1};
      tbl[11] = '{1, 538, 410,   1, 0, 0, 2, 2};
      tbl[12] = '{0,   0,   0,   1, 1, 0, 0, 0};

      drive();
      #2 rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("reset_video", k, out_word(k), 40'h0);
         chk("reset_sel", k, out_sel(k), 40'h0);
         chk("reset_switching", k, out_sw(k), 40'h0);
         m_rst(k);
      end
      repeat (3) tick();
      rst = 1'b0;
      repeat (200) tick();

      for (int t = 0; t < 13; t++) begin
         x  = 12'(tbl[t].x);
         y  = 12'(tbl[t].y);
         ml = tbl[t].click;
         rv = tbl[t].rv;
         ri = 2'(tbl[t].ri);
         tick();
         rv = 1'b0;
         for (int h = 1; h < tbl[t].hold; h++) tick();
         ml = 1'b0;
         repeat (400) tick();
         chk("table_sel", 0, out_sel(0), 40'(tbl[t].exp_a));
         chk("table_sel", 1, out_sel(1), 40'(tbl[t].exp_b));
         chk("table_idle", 0, out_sw(0), 40'h0);
         chk("table_idle", 1, out_sw(1), 40'h0);
      end

      // A request arriving while a switch is pending must not retarget it.
      x = 12'd500; y = 12'd380; ml = 1'b1;
      tick();
      ml = 1'b0; rv = 1'b1; ri = 2'd3;
      tick();
      rv = 1'b0;
      repeat (400) tick();
      chk("pending_ignores_req", 0, out_sel(0), 40'd1);
      chk("pending_ignores_req", 1, out_sel(1), 40'd1);

      // Asynchronous reset in the middle of the black frame.
      ml = 1'b1;
      tick();
      ml = 1'b0;
      begin
         int guard;
         guard = 0;
         while (m_st[0] != 2 && guard < 300) begin
            tick();
            guard++;
         end
         chk("reach_blank", 0, 40'(m_st[0] == 2), 40'h1);
      end
      repeat (5) tick();
      chk("blank_before_rst", 0, out_sw(0), 40'h1);
      #3 rst = 1'b1;
      #1;
      for (int k = 0; k < 2; k++) begin
         chk("midblank_rst_video", k, out_word(k), 40'h0);
         chk("midblank_rst_sel", k, out_sel(k), 40'h0);
         chk("midblank_rst_switching", k, out_sw(k), 40'h0);
      end
      tick();
      rst = 1'b0;
      repeat (200) tick();
      chk("after_rst_sel", 0, out_sel(0), 40'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule

`default_nettype wire
